// File: rtl/ringbuffer_ctrl.sv
`timescale 1ns/1ps
// ringbuffer_ctrl: sequences the LPC capture ring buffer.
// Producer side writes one record per in_valid bytewise into the capture RAM
// at the ringbuffer write slot and commits it (rb_write_done). Consumer side
// drains committed slots bytewise to the UART (out_valid/out_ready) and
// releases each slot (rb_read_done).
// Ports:
//   clock, reset            rising-edge clock, async active-low reset
//   in_valid, in_data       captured record (byte 0 = MSB byte)
//   rb_write_done/read_done commit / release pulses to the ringbuffer
//   rb_write_addr/read_addr ringbuffer slots, rb_empty/rb_full its flags
//   ram_we/waddr/wdata      capture RAM write port {slot, byte index}
//   ram_raddr/rdata         capture RAM read port, 1-cycle read latency
//   out_valid/data/ready    byte stream to the UART transmitter
//   overflow_count          saturating count of dropped records
//   busy                    either FSM not idle
module ringbuffer_ctrl #(
    parameter int  BITS  = 7,
    parameter int  BYTES = 4,
    localparam int IDX_W = $clog2(BYTES)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [8*BYTES-1:0]     in_data,
    output logic                   rb_write_done,
    output logic                   rb_read_done,
    input  logic [BITS-1:0]        rb_write_addr,
    input  logic [BITS-1:0]        rb_read_addr,
    input  logic                   rb_empty,
    input  logic                   rb_full,
    output logic                   ram_we,
    output logic [BITS+IDX_W-1:0]  ram_waddr,
    output logic [7:0]             ram_wdata,
    output logic [BITS+IDX_W-1:0]  ram_raddr,
    input  logic [7:0]             ram_rdata,
    output logic                   out_valid,
    output logic [7:0]             out_data,
    input  logic                   out_ready,
    output logic [15:0]            overflow_count,
    output logic                   busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    typedef enum logic [1:0] {
        W_IDLE,
        W_WRITE,
        W_COMMIT,
        W_GUARD
    } wstate_t;

    typedef enum logic [2:0] {
        R_IDLE,
        R_ADDR,
        R_DATA,
        R_SEND,
        R_RELEASE,
        R_GUARD
    } rstate_t;

    wstate_t             wstate_q, wstate_d;
    logic [8*BYTES-1:0]  shadow_q, shadow_d;
    logic [BITS-1:0]     wslot_q, wslot_d;
    logic [IDX_W-1:0]    widx_q, widx_d;
    logic [15:0]         ovf_q, ovf_d;
    logic [8*BYTES-1:0]  wshift;
    logic                drop;

    rstate_t             rstate_q, rstate_d;
    logic [BITS-1:0]     rslot_q, rslot_d;
    logic [IDX_W-1:0]    ridx_q, ridx_d;
    logic                ovalid_q, ovalid_d;
    logic [7:0]          odata_q, odata_d;

    // ---------------- write side ----------------
    always_comb begin
        wstate_d      = wstate_q;
        shadow_d      = shadow_q;
        wslot_d       = wslot_q;
        widx_d        = widx_q;
        ovf_d         = ovf_q;
        ram_we        = 1'b0;
        ram_waddr     = '0;
        ram_wdata     = '0;
        rb_write_done = 1'b0;
        // Shift the current byte up to the MSB position (byte 0 is MSB).
        wshift        = shadow_q << {widx_q, 3'b000};
        drop          = in_valid && ((wstate_q != W_IDLE) || rb_full);

        unique case (wstate_q)
            W_IDLE: begin
                if (in_valid && !rb_full) begin
                    shadow_d = in_data;
                    wslot_d  = rb_write_addr;
                    widx_d   = '0;
                    wstate_d = W_WRITE;
                end
            end
            W_WRITE: begin
                ram_we    = 1'b1;
                ram_waddr = {wslot_q, widx_q};
                ram_wdata = wshift[8*BYTES-1 -: 8];
                widx_d    = widx_q + 1'b1;
                if (widx_q == LAST_IDX) begin
                    wstate_d = W_COMMIT;
                end
            end
            W_COMMIT: begin
                rb_write_done = 1'b1;
                wstate_d      = W_GUARD;
            end
            W_GUARD: begin
                // Let the ringbuffer pointers and flags settle.
                wstate_d = W_IDLE;
            end
        endcase

        if (drop && (ovf_q != 16'hFFFF)) begin
            ovf_d = ovf_q + 16'd1;
        end
    end

    // ---------------- read side ----------------
    always_comb begin
        rstate_d     = rstate_q;
        rslot_d      = rslot_q;
        ridx_d       = ridx_q;
        ovalid_d     = ovalid_q;
        odata_d      = odata_q;
        rb_read_done = 1'b0;

        unique case (rstate_q)
            R_IDLE: begin
                if (!rb_empty) begin
                    rslot_d  = rb_read_addr;
                    ridx_d   = '0;
                    rstate_d = R_ADDR;
                end
            end
            R_ADDR: begin
                rstate_d = R_DATA;
            end
            R_DATA: begin
                odata_d  = ram_rdata;
                ovalid_d = 1'b1;
                rstate_d = R_SEND;
            end
            R_SEND: begin
                if (out_ready) begin
                    ovalid_d = 1'b0;
                    if (ridx_q == LAST_IDX) begin
                        rstate_d = R_RELEASE;
                    end else begin
                        ridx_d   = ridx_q + 1'b1;
                        rstate_d = R_ADDR;
                    end
                end
            end
            R_RELEASE: begin
                rb_read_done = 1'b1;
                rstate_d     = R_GUARD;
            end
            R_GUARD: begin
                rstate_d = R_IDLE;
            end
            default: begin
                rstate_d = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wstate_q <= W_IDLE;
            shadow_q <= '0;
            wslot_q  <= '0;
            widx_q   <= '0;
            ovf_q    <= '0;
            rstate_q <= R_IDLE;
            rslot_q  <= '0;
            ridx_q   <= '0;
            ovalid_q <= 1'b0;
            odata_q  <= '0;
        end else begin
            wstate_q <= wstate_d;
            shadow_q <= shadow_d;
            wslot_q  <= wslot_d;
            widx_q   <= widx_d;
            ovf_q    <= ovf_d;
            rstate_q <= rstate_d;
            rslot_q  <= rslot_d;
            ridx_q   <= ridx_d;
            ovalid_q <= ovalid_d;
            odata_q  <= odata_d;
        end
    end

    // Held through R_DATA too; the RAM samples it at the end of R_ADDR.
    assign ram_raddr      = {rslot_q, ridx_q};
    assign out_valid      = ovalid_q;
    assign out_data       = odata_q;
    assign overflow_count = ovf_q;
    assign busy           = (wstate_q != W_IDLE) || (rstate_q != R_IDLE);

endmodule

// File: tb/tb_ringbuffer_ctrl.sv
`timescale 1ns/1ps
// Bench for ringbuffer_ctrl: ringbuffer + RAM environment, queue-based
// reference model with a per-cycle compare process, directed + random stimulus.
module tb_ringbuffer_ctrl;

    localparam int BITS  = 7;
    localparam int BYTES = 4;
    localparam int IDX_W = 2;
    localparam int AW    = BITS + IDX_W;
    localparam int SLOTS = 2 ** BITS;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid;
    logic [31:0]     in_data;
    logic            rb_write_done, rb_read_done;
    logic [BITS-1:0] rb_write_addr, rb_read_addr;
    logic            rb_empty, rb_full;
    logic            ram_we;
    logic [AW-1:0]   ram_waddr, ram_raddr;
    logic [7:0]      ram_wdata, ram_rdata;
    logic            out_valid, out_ready;
    logic [7:0]      out_data;
    logic [15:0]     overflow_count;
    logic            busy;

    ringbuffer_ctrl #(.BITS(BITS), .BYTES(BYTES)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_data(in_data),
        .rb_write_done(rb_write_done), .rb_read_done(rb_read_done),
        .rb_write_addr(rb_write_addr), .rb_read_addr(rb_read_addr),
        .rb_empty(rb_empty), .rb_full(rb_full),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .overflow_count(overflow_count), .busy(busy)
    );

    always #5 clock = ~clock;

    // Ringbuffer pointer block (shares the reset net).
    logic [BITS:0] wptr, rptr;
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (rb_write_done) wptr <= wptr + 1'b1;
            if (rb_read_done)  rptr <= rptr + 1'b1;
        end
    end
    assign rb_write_addr = wptr[BITS-1:0];
    assign rb_read_addr  = rptr[BITS-1:0];
    assign rb_empty      = (wptr == rptr);
    assign rb_full       = ((wptr - rptr) == (BITS+1)'(SLOTS));

    // Capture RAM, registered read.
    logic [7:0] mem [2**AW];
    always @(posedge clock) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        ram_rdata <= mem[ram_raddr];
    end

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    bit started = 0;

    // Reference model state
    int              acc_c, rel_c, nsent, ovf;
    logic [BITS-1:0] acc_slot;
    logic [31:0]     acc_rec;
    logic [7:0]      exp_q[$];
    int              wd_cnt = 0, rd_cnt = 0;
    int              last_acc_c = 0, last_wd_c = 0;
    logic [7:0]      uart_log[$];
    int              wr_log[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        acc_c = -1000;
        rel_c = -1000;
        nsent = 0;
        ovf   = 0;
        exp_q.delete();
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Per-cycle compare against the model.
    always @(negedge clock) begin : cmp
        int   c;
        int   idx;
        logic we_exp;
        if (started && reset === 1'b1) begin
            c = cyc;
            we_exp = (c > acc_c) && (c <= acc_c + BYTES);
            check("ram_we", ram_we, we_exp);
            if (we_exp && ram_we) begin
                idx = c - acc_c - 1;
                check("ram_waddr", ram_waddr, {acc_slot, IDX_W'(idx)});
                check("ram_wdata", ram_wdata, 8'(acc_rec >> (8 * (BYTES - 1 - idx))));
                wr_log.push_back(int'(ram_waddr));
            end
            check("rb_write_done", rb_write_done, c == acc_c + BYTES + 1);
            if (rb_write_done) begin
                wd_cnt++;
                last_wd_c = c;
            end
            check("rb_read_done", rb_read_done, c == rel_c);
            if (rb_read_done) rd_cnt++;
            check("overflow_count", overflow_count, ovf[15:0]);
            if (c > acc_c && c <= acc_c + BYTES + 2) check("busy_w", busy, 1'b1);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("out_valid_spurious", out_valid, 1'b0);
                end else begin
                    check("out_data", out_data, exp_q[0]);
                    if (out_ready) begin
                        uart_log.push_back(out_data);
                        void'(exp_q.pop_front());
                        nsent++;
                        if (nsent % BYTES == 0) rel_c = c + 1;
                    end
                end
            end
            if (in_valid) begin
                if (c >= acc_c + BYTES + 3 && !rb_full) begin
                    acc_c      = c;
                    last_acc_c = c;
                    acc_slot   = rb_write_addr;
                    acc_rec    = in_data;
                    for (int i = 0; i < BYTES; i++)
                        exp_q.push_back(8'(in_data >> (8 * (BYTES - 1 - i))));
                end else if (ovf < 65535) begin
                    ovf++;
                end
            end
        end
    end

    task automatic send(input logic [31:0] d);
        @(posedge clock); #1;
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
    endtask

    task automatic wait_quiet(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clock); #3;
            if (!busy && rb_empty && exp_q.size() == 0 && !out_valid) begin
                ok = 1;
                break;
            end
        end
        check("quiet_timeout", ok, 1'b1);
    endtask

    task automatic wait_valid(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clock); #3;
            if (out_valid) begin
                ok = 1;
                break;
            end
        end
        check("out_valid_timeout", ok, 1'b1);
    endtask

    task automatic check_reset_outputs();
        check("rst_write_done", rb_write_done, 1'b0);
        check("rst_read_done", rb_read_done, 1'b0);
        check("rst_ram_we", ram_we, 1'b0);
        check("rst_waddr", ram_waddr, '0);
        check("rst_wdata", ram_wdata, '0);
        check("rst_raddr", ram_raddr, '0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_overflow", overflow_count, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_rb_empty", rb_empty, 1'b1);
    endtask

    task automatic pulse_reset();
        @(posedge clock); #2;
        reset = 1'b0;
        #0.5;
        model_reset();
        check_reset_outputs();
        #0.5;
        reset = 1'b1;
    endtask

    task automatic check_bytes(input string name, input logic [31:0] rec);
        check({name, "_n"}, uart_log.size(), 4);
        if (uart_log.size() == 4)
            for (int i = 0; i < 4; i++)
                check(name, uart_log[i], 8'(rec >> (8 * (3 - i))));
    endtask

    int wd0, rd0;

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();
        #1 reset = 1'b0;
        #2 check_reset_outputs();
        @(posedge clock); #2;
        reset   = 1'b1;
        started = 1;

        // Single record, free-flowing UART.
        out_ready = 1'b1;
        uart_log.delete();
        wr_log.delete();
        wd0 = wd_cnt;
        rd0 = rd_cnt;
        send(32'hA1B2C3D4);
        wait_quiet(100);
        check_bytes("single_uart", 32'hA1B2C3D4);
        check("single_wr_n", wr_log.size(), 4);
        if (wr_log.size() == 4)
            for (int i = 0; i < 4; i++) check("single_waddr", wr_log[i], i);
        check("single_commit_lat", last_wd_c - last_acc_c, 5);
        check("single_commits", wd_cnt - wd0, 1);
        check("single_releases", rd_cnt - rd0, 1);
        check("single_empty", rb_empty, 1'b1);

        // Backpressure: hold for 10 cycles.
        out_ready = 1'b0;
        uart_log.delete();
        send(32'hA1B2C3D4);
        wait_valid(50);
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #3;
            check("bp_valid", out_valid, 1'b1);
            check("bp_data", out_data, 8'hA1);
        end
        out_ready = 1'b1;
        wait_quiet(100);
        check_bytes("bp_uart", 32'hA1B2C3D4);

        // Second in_valid 2 cycles after the first is dropped.
        wd0 = wd_cnt;
        rd0 = rd_cnt;
        send(32'h11223344);
        send(32'h55667788);
        wait_quiet(100);
        check("drop_ovf", overflow_count, 16'd1);
        check("drop_commits", wd_cnt - wd0, 1);
        check("drop_releases", rd_cnt - rd0, 1);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clock); #1;
            in_valid  = ($urandom_range(0, 3) == 0);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 1) == 1);
        end
        @(posedge clock); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_quiet(3000);

        // Reset mid-run.
        pulse_reset();
        idle(5);

        // Fill the ring, overflow, drain, wrap.
        out_ready = 1'b0;
        wd0 = wd_cnt;
        rd0 = rd_cnt;
        for (int i = 0; i < SLOTS + 3; i++) begin
            send($urandom);
            idle(BYTES + 1);
        end
        @(posedge clock); #3;
        check("full_flag", rb_full, 1'b1);
        check("full_ovf", overflow_count, 16'd3);
        check("full_commits", wd_cnt - wd0, SLOTS);
        out_ready = 1'b1;
        wait_quiet(SLOTS * BYTES * 8);
        check("drain_releases", rd_cnt - rd0, SLOTS);
        uart_log.delete();
        wr_log.delete();
        send(32'h5A6B7C8D);
        wait_quiet(100);
        check("wrap_wr_n", wr_log.size(), 4);
        if (wr_log.size() == 4)
            for (int i = 0; i < 4; i++) check("wrap_waddr", wr_log[i], i);
        check_bytes("wrap_uart", 32'h5A6B7C8D);

        // Reset during W_WRITE byte 2 while the reader sits in R_SEND.
        out_ready = 1'b0;
        send(32'hCAFEF00D);
        wait_valid(50);
        send(32'hDEADBEEF);
        idle(1);
        pulse_reset();
        wd0 = wd_cnt;
        rd0 = rd_cnt;
        idle(10);
        @(posedge clock); #3;
        check("mid_out_valid", out_valid, 1'b0);
        check("mid_ovf", overflow_count, 16'd0);
        check("mid_commits", wd_cnt - wd0, 0);
        check("mid_releases", rd_cnt - rd0, 0);
        out_ready = 1'b1;
        uart_log.delete();
        send(32'h0F1E2D3C);
        wait_quiet(100);
        check_bytes("post_uart", 32'h0F1E2D3C);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
